// File: rtl/chdr_strc_responder.sv
// chdr_strc_responder
//   Parses CHDR stream command packets (INIT / PING / RESYNC) arriving on the
//   command AXI-Stream input, applies them to the endpoint transfer counters,
//   and answers each with a 5-word CHDR stream status packet addressed back to
//   the commanding endpoint. Non-command packets are discarded.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   my_epid              local EPID, reported as status src_epid
//   xfer_pkt_stb/bytes   ingress buffer consumption strobe and byte count
//   s_axis_chdr_*        command input (64-bit CHDR)
//   m_axis_chdr_*        status output (64-bit CHDR)
//   drop_stb             1-cycle pulse per discarded non-command packet
//   xfer_count_pkts      40-bit packet counter
//   xfer_count_bytes     64-bit byte counter
module chdr_strc_responder #(
   parameter logic [39:0] BUFF_CAPACITY_BYTES = 40'd65536,
   parameter logic [23:0] BUFF_CAPACITY_PKTS  = 24'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] my_epid,
   input  logic        xfer_pkt_stb,
   input  logic [15:0] xfer_bytes,
   input  logic [63:0] s_axis_chdr_tdata,
   input  logic        s_axis_chdr_tlast,
   input  logic        s_axis_chdr_tvalid,
   output logic        s_axis_chdr_tready,
   output logic [63:0] m_axis_chdr_tdata,
   output logic        m_axis_chdr_tlast,
   output logic        m_axis_chdr_tvalid,
   input  logic        m_axis_chdr_tready,
   output logic        drop_stb,
   output logic [39:0] xfer_count_pkts,
   output logic [63:0] xfer_count_bytes
);

   typedef enum logic [2:0] {HDR, MDATA, CMD0, CMD1, DRAIN, RESP} state_t;

   typedef struct packed {
      logic [39:0] num_pkts;
      logic [3:0]  op_data;
      logic [3:0]  op_code;
      logic [15:0] src_epid;
   } cmd0_t;

   localparam logic [2:0] PKT_STRM_CMD  = 3'd2;
   localparam logic [2:0] PKT_STRM_STS  = 3'd1;
   localparam logic [3:0] OP_INIT       = 4'd0;
   localparam logic [3:0] OP_RESYNC     = 4'd2;
   localparam logic [3:0] STS_OKAY      = 4'd0;
   localparam logic [3:0] STS_CMDERR    = 4'd1;

   state_t      state, state_nxt;
   cmd0_t       cmd0_q;
   logic [63:0] num_bytes_q;
   logic [6:0]  mdata_cnt;
   logic        cmd_pending;
   logic [2:0]  beat;
   logic [15:0] resp_seq;
   logic [15:0] resp_dst;
   logic [3:0]  resp_sts;
   logic [39:0] snap_pkts;
   logic [63:0] snap_bytes;

   logic        s_beat, m_beat, s_last;
   logic        go_resp, trunc, act_ok;
   logic [2:0]  hdr_type;
   logic [6:0]  hdr_nmd;
   logic [39:0] pkts_nxt;
   logic [63:0] bytes_nxt, resync_bytes;
   logic [15:0] dst_nxt;
   logic [3:0]  sts_nxt;

   assign s_axis_chdr_tready = !rst && (state != RESP);
   assign m_axis_chdr_tvalid = (state == RESP);
   assign m_axis_chdr_tlast  = (state == RESP) && (beat == 3'd4);
   assign s_beat             = s_axis_chdr_tvalid && s_axis_chdr_tready;
   assign m_beat             = m_axis_chdr_tvalid && m_axis_chdr_tready;
   assign s_last             = s_axis_chdr_tlast;
   assign hdr_type           = s_axis_chdr_tdata[57:55];
   assign hdr_nmd            = s_axis_chdr_tdata[54:48];

   // op_data is captured with the command but no opcode here consumes it
   logic unused_op_data;
   assign unused_op_data = ^cmd0_q.op_data;

   always_comb begin
      state_nxt = state;
      go_resp   = 1'b0;
      trunc     = 1'b0;
      if (s_beat) begin
         case (state)
            HDR:
               if (hdr_type == PKT_STRM_CMD) begin
                  if (s_last) begin
                     state_nxt = RESP; go_resp = 1'b1; trunc = 1'b1;
                  end else begin
                     state_nxt = (hdr_nmd != 7'd0) ? MDATA : CMD0;
                  end
               end else begin
                  state_nxt = s_last ? HDR : DRAIN;
               end
            MDATA:
               if (s_last) begin
                  state_nxt = RESP; go_resp = 1'b1; trunc = 1'b1;
               end else if (mdata_cnt == 7'd1) begin
                  state_nxt = CMD0;
               end
            CMD0:
               if (s_last) begin
                  state_nxt = RESP; go_resp = 1'b1; trunc = 1'b1;
               end else begin
                  state_nxt = CMD1;
               end
            CMD1:
               if (s_last) begin
                  state_nxt = RESP; go_resp = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            DRAIN:
               if (s_last) begin
                  if (cmd_pending) begin
                     state_nxt = RESP; go_resp = 1'b1;
                  end else begin
                     state_nxt = HDR;
                  end
               end
            default: ;
         endcase
      end
      if ((state == RESP) && m_beat && (beat == 3'd4))
         state_nxt = HDR;
   end

   // A complete command acts on the counters; truncated ones only report.
   // num_bytes is still on the bus when the command ends on CMD1.
   assign act_ok       = go_resp && !trunc;
   assign resync_bytes = (state == CMD1) ? s_axis_chdr_tdata : num_bytes_q;

   always_comb begin
      pkts_nxt  = xfer_count_pkts;
      bytes_nxt = xfer_count_bytes;
      if (act_ok && (cmd0_q.op_code == OP_INIT)) begin
         pkts_nxt  = '0;
         bytes_nxt = '0;
      end else if (act_ok && (cmd0_q.op_code == OP_RESYNC)) begin
         pkts_nxt  = cmd0_q.num_pkts;
         bytes_nxt = resync_bytes;
      end else if (xfer_pkt_stb) begin
         pkts_nxt  = xfer_count_pkts + 40'd1;
         bytes_nxt = xfer_count_bytes + {48'd0, xfer_bytes};
      end
   end

   always_comb begin
      sts_nxt = (trunc || (cmd0_q.op_code > OP_RESYNC)) ? STS_CMDERR : STS_OKAY;
      case (state)
         CMD0:        dst_nxt = s_axis_chdr_tdata[15:0];
         CMD1, DRAIN: dst_nxt = cmd0_q.src_epid;
         default:     dst_nxt = 16'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= HDR;
         cmd0_q           <= '0;
         num_bytes_q      <= '0;
         mdata_cnt        <= '0;
         cmd_pending      <= 1'b0;
         beat             <= '0;
         resp_seq         <= '0;
         resp_dst         <= '0;
         resp_sts         <= '0;
         snap_pkts        <= '0;
         snap_bytes       <= '0;
         drop_stb         <= 1'b0;
         xfer_count_pkts  <= '0;
         xfer_count_bytes <= '0;
      end else begin
         state            <= state_nxt;
         drop_stb         <= 1'b0;
         xfer_count_pkts  <= pkts_nxt;
         xfer_count_bytes <= bytes_nxt;
         if (s_beat) begin
            case (state)
               HDR: begin
                  mdata_cnt   <= hdr_nmd;
                  cmd_pending <= 1'b0;
                  if (hdr_type != PKT_STRM_CMD) drop_stb <= 1'b1;
               end
               MDATA: mdata_cnt <= mdata_cnt - 7'd1;
               CMD0:  cmd0_q    <= cmd0_t'(s_axis_chdr_tdata);
               CMD1: begin
                  num_bytes_q <= s_axis_chdr_tdata;
                  cmd_pending <= !s_last;
               end
               default: ;
            endcase
         end
         if (go_resp) begin
            cmd_pending <= 1'b0;
            beat        <= '0;
            resp_dst    <= dst_nxt;
            resp_sts    <= sts_nxt;
            snap_pkts   <= pkts_nxt;
            snap_bytes  <= bytes_nxt;
         end
         if (m_beat) begin
            beat <= beat + 3'd1;
            if (beat == 3'd4) resp_seq <= resp_seq + 16'd1;
         end
      end
   end

   always_comb begin
      m_axis_chdr_tdata = '0;
      if (state == RESP) begin
         case (beat)
            3'd0:    m_axis_chdr_tdata = {6'b0, PKT_STRM_STS, 7'd0, resp_seq, 16'd40, resp_dst};
            3'd1:    m_axis_chdr_tdata = {BUFF_CAPACITY_BYTES, 4'b0, resp_sts, my_epid};
            3'd2:    m_axis_chdr_tdata = {snap_pkts, BUFF_CAPACITY_PKTS};
            3'd3:    m_axis_chdr_tdata = snap_bytes;
            default: m_axis_chdr_tdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_chdr_strc_responder.sv
module tb_chdr_strc_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] my_epid = 16'hBEEF;
   logic        xfer_pkt_stb = 1'b0;
   logic [15:0] xfer_bytes = '0;
   logic [63:0] s_tdata = '0;
   logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
   logic [63:0] m_tdata;
   logic        m_tlast, m_tvalid, m_tready = 1'b0;
   logic        drop_stb;
   logic [39:0] cnt_pkts;
   logic [63:0] cnt_bytes;

   int n_checks = 0, n_fail = 0, drop_cnt = 0;
   logic [63:0] pkt_q[$];
   logic [63:0] rw [5];
   int first_cyc;

   chdr_strc_responder dut (
      .clk(clk), .rst(rst), .my_epid(my_epid),
      .xfer_pkt_stb(xfer_pkt_stb), .xfer_bytes(xfer_bytes),
      .s_axis_chdr_tdata(s_tdata), .s_axis_chdr_tlast(s_tlast),
      .s_axis_chdr_tvalid(s_tvalid), .s_axis_chdr_tready(s_tready),
      .m_axis_chdr_tdata(m_tdata), .m_axis_chdr_tlast(m_tlast),
      .m_axis_chdr_tvalid(m_tvalid), .m_axis_chdr_tready(m_tready),
      .drop_stb(drop_stb), .xfer_count_pkts(cnt_pkts), .xfer_count_bytes(cnt_bytes)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (drop_stb) drop_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] chdr_hdr(input logic [2:0] t, input logic [6:0] nmd,
                                            input logic [15:0] len, input logic [15:0] dst);
      return {6'b0, t, nmd, 16'h0077, len, dst};
   endfunction

   function automatic logic [63:0] cmd_w0(input logic [39:0] np, input logic [3:0] op,
                                          input logic [15:0] src);
      return {np, 4'h0, op, src};
   endfunction

   // entered and left at posedge+1
   task automatic send_beat(input logic [63:0] d, input logic l);
      logic rdy;
      int   n = 0;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      do begin
         @(negedge clk); rdy = s_tready; @(posedge clk); n++;
      end while (!rdy && n < 100);
      if (!rdy) check("s_handshake_timeout", 0, 1);
      #1 s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_pkt();
      while (pkt_q.size() > 0) begin
         logic [63:0] d;
         d = pkt_q.pop_front();
         send_beat(d, pkt_q.size() == 0);
      end
   endtask

   task automatic strobe(input int n, input logic [15:0] b);
      for (int i = 0; i < n; i++) begin
         xfer_pkt_stb = 1'b1; xfer_bytes = b;
         @(posedge clk); #1;
      end
      xfer_pkt_stb = 1'b0;
   endtask

   // collects one 5-beat response; random tready stalls when stall=1
   task automatic recv_resp(input bit stall);
      int idx = 0, guard = 0;
      bit held = 0, rdy;
      logic [63:0] hold_d;
      first_cyc = -1;
      while (idx < 5 && guard < 200) begin
         @(negedge clk); guard++;
         if (m_tvalid) begin
            if (first_cyc < 0) first_cyc = guard;
            if (held) check("stable_tdata", m_tdata, hold_d);
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_tready = rdy;
            if (rdy) begin
               rw[idx] = m_tdata;
               check("tlast", {63'd0, m_tlast}, {63'd0, idx == 4});
               idx++; held = 0;
            end else begin
               held = 1; hold_d = m_tdata;
            end
         end else begin
            if (held) check("tvalid_held", 0, 1);
            held = 0; m_tready = 1'b0;
         end
      end
      check("resp_beats", idx, 5);
      @(posedge clk); #1 m_tready = 1'b0;
   endtask

   task automatic check_resp(input logic [15:0] seq, input logic [15:0] dst, input logic [3:0] st,
                             input logic [39:0] np, input logic [63:0] nb);
      check("sts_hdr", rw[0], {6'b0, 3'd1, 7'd0, seq, 16'd40, dst});
      check("sts_w0",  rw[1], {40'd65536, 4'b0, st, 16'hBEEF});
      check("sts_w1",  rw[2], {np, 24'd64});
      check("sts_w2",  rw[3], nb);
      check("sts_w3",  rw[4], 64'd0);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready", s_tready, 0);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_drop", drop_stb, 0);
      check("rst_pkts", cnt_pkts, 0);
      check("rst_bytes", cnt_bytes, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("tready_after_rst", s_tready, 1);
      @(posedge clk); #1;

      // INIT after 3 x 100 bytes
      strobe(3, 16'd100);
      @(negedge clk);
      check("pre_init_pkts", cnt_pkts, 3);
      check("pre_init_bytes", cnt_bytes, 300);
      @(posedge clk); #1;
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd24, 16'hBEEF), cmd_w0(40'd0, 4'd0, 16'h0A0B), 64'd0};
      send_pkt();
      recv_resp(0);
      check("latency", first_cyc, 1);
      check_resp(16'd0, 16'h0A0B, 4'd0, 40'd0, 64'd0);
      check("init_pkts", cnt_pkts, 0);
      check("init_bytes", cnt_bytes, 0);

      // PING after 5 x 8 bytes
      strobe(5, 16'd8);
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd24, 16'hBEEF), cmd_w0(40'd0, 4'd1, 16'h0C0D), 64'd0};
      send_pkt();
      recv_resp(0);
      check_resp(16'd1, 16'h0C0D, 4'd0, 40'd5, 64'd40);

      // RESYNC to the top of the packet counter, then wrap
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd24, 16'hBEEF), cmd_w0(40'hFF_FFFF_FFFF, 4'd2, 16'h0E0F),
                64'h0000_0000_0000_1000};
      send_pkt();
      recv_resp(0);
      check_resp(16'd2, 16'h0E0F, 4'd0, 40'hFF_FFFF_FFFF, 64'h1000);
      strobe(2, 16'd10);
      @(negedge clk);
      check("wrap_pkts", cnt_pkts, 1);
      check("wrap_bytes", cnt_bytes, 64'h1014);
      @(posedge clk); #1;

      // metadata skipped, unknown opcode
      pkt_q = '{chdr_hdr(3'd2, 7'd2, 16'd40, 16'hBEEF), 64'hDEAD_DEAD_DEAD_DEAD,
                64'hBEEF_BEEF_BEEF_BEEF, cmd_w0(40'd99, 4'd7, 16'h1111), 64'd0};
      send_pkt();
      recv_resp(0);
      check_resp(16'd3, 16'h1111, 4'd1, 40'd1, 64'h1014);
      check("badop_pkts", cnt_pkts, 1);

      // data packet is dropped
      pkt_q = '{chdr_hdr(3'd6, 7'd0, 16'd32, 16'hBEEF), 64'd1, 64'd2, 64'd3};
      send_pkt();
      repeat (3) begin
         @(negedge clk);
         check("drop_no_output", m_tvalid, 0);
      end
      check("drop_pulses", drop_cnt, 1);
      @(posedge clk); #1;

      // command truncated after header
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd8, 16'hBEEF)};
      send_pkt();
      recv_resp(0);
      check_resp(16'd4, 16'h0000, 4'd1, 40'd1, 64'h1014);

      // random output stalls
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd24, 16'hBEEF), cmd_w0(40'd0, 4'd1, 16'h0606), 64'd0};
      send_pkt();
      recv_resp(1);
      check_resp(16'd5, 16'h0606, 4'd0, 40'd1, 64'h1014);

      // reset while beat 3 is presented
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd24, 16'hBEEF), cmd_w0(40'd0, 4'd1, 16'h0707), 64'd0};
      send_pkt();
      begin
         int idx = 0, guard = 0;
         while (idx < 3 && guard < 50) begin
            @(negedge clk); guard++;
            if (m_tvalid) begin m_tready = 1'b1; idx++; end
            else m_tready = 1'b0;
         end
         check("partial_beats", idx, 3);
         @(negedge clk);
         check("beat3_data", m_tdata, 64'h1014);
         m_tready = 1'b0; rst = 1'b1;
         @(negedge clk);
         check("rst_mid_tvalid", m_tvalid, 0);
         check("rst_mid_pkts", cnt_pkts, 0);
         @(posedge clk); #1 rst = 1'b0;
      end

      // after reset: sequence restarts; trailing word exercises DRAIN
      pkt_q = '{chdr_hdr(3'd2, 7'd0, 16'd32, 16'hBEEF), cmd_w0(40'd0, 4'd1, 16'h0808), 64'd0, 64'd5};
      send_pkt();
      recv_resp(0);
      check_resp(16'd0, 16'h0808, 4'd0, 40'd0, 64'd0);
      check("drop_total", drop_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
